mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory of the multicycle MIPS between two requesters:
//  the CPU (fetch/load/store, priority port) and a DMA/debug engine. Serialises accesses, models a
//  fixed memory latency, returns read data with a one-cycle ack pulse, and stalls the CPU while busy.
//  Sits between the multicycle datapath/controller and the memory in top.
// PARAMETERS
//  WIDTH      32  data/address width
//  MEM_LAT    2   memory access cycles per transaction (>=1)
//  MAX_BURST  4   consecutive CPU grants allowed while DMA waits (used only with fairness macro)
// PORTS
//  clk        in   1      system clock, all state updates on posedge
//  reset      in   1      synchronous, active-high
//  cpu_req    in   1      CPU access request, held with cpu_we/adr/wd stable until cpu_ack
//  cpu_we     in   1      1 = write, 0 = read
//  cpu_adr    in   WIDTH  CPU byte address
//  cpu_wd     in   WIDTH  CPU write data
//  cpu_rd     out  WIDTH  read data, valid in cycle cpu_ack=1
//  cpu_ack    out  1      one-cycle completion pulse
//  cpu_stall  out  1      cpu_req & ~cpu_ack (combinational)
//  dma_req/dma_we/dma_adr/dma_wd/dma_rd/dma_ack  same semantics for DMA port
//  mem_we     out  1      memory write strobe
//  mem_adr    out  WIDTH  memory address
//  mem_wd     out  WIDTH  memory write data
//  mem_rd     in   WIDTH  memory read data (valid in last BUSY cycle)
//  mem_owner  out  1      0 = CPU, 1 = DMA; owner of current/last transaction
// BEHAVIOUR
//  Reset: state IDLE; cpu_ack, dma_ack, mem_we, mem_owner = 0; cpu_rd, dma_rd, mem_adr, mem_wd = 0;
//   latency counter and streak counter = 0. Reset mid-transaction aborts it: no ack issued, mem_we
//   never reasserted; a write whose strobe already fired stays committed.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: if any req, pick winner, latch we/adr/wd and owner, cnt <= MEM_LAT-1, go BUSY; else stay.
//   BUSY: mem_adr/mem_wd driven from latches; mem_we = latched_we only in first BUSY cycle
//     (exactly one strobe per write). cnt decrements; at cnt==0 capture mem_rd into owner's rd reg
//     (writes leave rd unchanged), go DONE.
//   DONE: owner's ack = 1 for exactly this cycle; go IDLE. Requests ignored in DONE.
//  Latency: req first seen in IDLE cycle 0 -> ack in cycle MEM_LAT+1. Back-to-back throughput:
//   one transaction per MEM_LAT+2 cycles. Requester drops or renews req on edge ending DONE.
//  Arbitration in IDLE: only one req -> that one wins. Both -> CPU wins (strict priority),
//   except as modified by MEMARB_FAIRNESS_EN. Never both acks high; never ack without prior grant.
//  Requester deasserting req before ack is illegal; arbiter completes the latched transaction anyway.
//  Address/data passed unmodified; no alignment checks (byte address, word memory decodes [31:2]).
// CONFIGURATION
//  MEMARB_FAIRNESS_EN defined: streak counter ($clog2(MAX_BURST+1) bits) increments on each CPU grant
//   made while dma_req=1, clears on DMA grant or on CPU grant with dma_req=0; when streak==MAX_BURST
//   and both request, DMA wins. Bounds DMA wait to MAX_BURST transactions.
//  Not defined: strict CPU priority, streak logic absent; DMA may starve under continuous CPU traffic.
// TESTING  (MEM_LAT=2, MAX_BURST=4, cycle 0 = first IDLE cycle with req)
//  CPU read adr 80, mem_rd=0xFFFFFFC0 -> cpu_ack=1 only in cycle 3, cpu_rd=0xFFFFFFC0, dma_ack=0.
//  CPU write adr 84 wd -64 -> mem_we=1 exactly one cycle (cycle 1), mem_adr=84, mem_wd=0xFFFFFFC0; ack cycle 3.
//  cpu_req & dma_req together, macro off -> cpu_ack cycle 3, mem_owner=1 from cycle 5, dma_ack cycle 7.
//  Continuous CPU reqs + held dma_req: macro on -> DMA granted after 4th CPU ack; macro off -> no dma_ack in 20 transactions.
//  reset=1 during BUSY of DMA write -> next cycle state IDLE, all outputs 0, no dma_ack, no second mem_we.
//  Lone dma_req read adr 0x10 -> granted in cycle 0, dma_ack cycle 3 with mem_rd value; cpu_stall stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU priority, DMA) serialiser for the shared unified memory with fixed access latency.
// Define MEMARB_FAIRNESS_EN to bound DMA wait to MAX_BURST back-to-back CPU grants.
//
//   state | meaning
//   IDLE  | no transaction; arbitrate and latch winner's request
//   BUSY  | memory access in progress, MEM_LAT cycles
//   DONE  | one-cycle ack pulse to owner
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MEM_LAT   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic [WIDTH-1:0] cpu_rd,
  output logic             cpu_ack,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [WIDTH-1:0] dma_adr,
  input  logic [WIDTH-1:0] dma_wd,
  output logic [WIDTH-1:0] dma_rd,
  output logic             dma_ack,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             mem_owner
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic          grant_dma;

`ifdef MEMARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_BURST + 1);
  logic [SW-1:0] streak;

  always_comb begin
    grant_dma = dma_req & (~cpu_req | (streak == SW'(MAX_BURST)));
  end
`else
  logic unused_max_burst;
  assign unused_max_burst = (MAX_BURST != 0);

  always_comb begin
    grant_dma = dma_req & ~cpu_req;
  end
`endif

  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rd    <= '0;
      dma_rd    <= '0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wd    <= '0;
      mem_owner <= 1'b0;
`ifdef MEMARB_FAIRNESS_EN
      streak    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req | dma_req) begin
            mem_owner <= grant_dma;
            lat_we    <= grant_dma ? dma_we  : cpu_we;
            mem_we    <= grant_dma ? dma_we  : cpu_we;
            mem_adr   <= grant_dma ? dma_adr : cpu_adr;
            mem_wd    <= grant_dma ? dma_wd  : cpu_wd;
            cnt       <= CW'(MEM_LAT - 1);
            state     <= BUSY;
`ifdef MEMARB_FAIRNESS_EN
            // streak counts CPU wins only while DMA is actually waiting
            if (!grant_dma && dma_req) streak <= streak + SW'(1);
            else                       streak <= '0;
`endif
          end
        end
        BUSY: begin
          mem_we <= 1'b0;
          if (cnt == '0) begin
            if (!lat_we) begin
              if (mem_owner) dma_rd <= mem_rd;
              else           cpu_rd <= mem_rd;
            end
            if (mem_owner) dma_ack <= 1'b1;
            else           cpu_ack <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level timing model (grant cycle g -> strobe g+1, ack g+MEM_LAT+1).
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int WIDTH = 32;
  localparam int MEM_LAT = 2;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_adr = 0, cpu_wd = 0;
  logic dma_req = 0, dma_we = 0;
  logic [31:0] dma_adr = 0, dma_wd = 0;
  logic [31:0] cpu_rd, dma_rd, mem_adr, mem_wd, mem_rd;
  logic cpu_ack, cpu_stall, dma_ack, mem_we, mem_owner;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit check_en = 0;

  mem_arbiter #(.WIDTH(WIDTH), .MEM_LAT(MEM_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
    .dma_rd(dma_rd), .dma_ack(dma_ack),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .mem_owner(mem_owner)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int idx);
    if (idx == 20) return 32'hFFFF_FFC0;
    if (idx == 4)  return 32'h1234_5678;
    return (32'(idx) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // environment memory: word-addressed by adr[7:2]
  logic [31:0] env_mem [0:63];
  bit   [63:0] env_wr;
  assign mem_rd = env_wr[mem_adr[7:2]] ? env_mem[mem_adr[7:2]] : init_val(int'(mem_adr[7:2]));
  always @(posedge clk) begin
    if (mem_we) begin
      env_mem[mem_adr[7:2]] <= mem_wd;
      env_wr[mem_adr[7:2]]  <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:63];
  bit   [63:0] ref_wr;
  bit          g_valid = 0, g_owner = 0, g_we = 0;
  int          g_cyc = 0, next_free = 0, streak = 0;
  logic [31:0] g_adr = 0, g_wd = 0, g_rdata = 0, e_cpu_rd = 0, e_dma_rd = 0;

  always @(negedge clk) begin
    logic e_mem_we, e_cpu_ack, e_dma_ack;
    bit pick_dma;
    int idx;
    if (g_valid && !g_we && cyc == g_cyc + MEM_LAT + 1) begin
      if (g_owner) e_dma_rd = g_rdata;
      else         e_cpu_rd = g_rdata;
    end
    e_mem_we  = g_valid && g_we && (cyc == g_cyc + 1);
    e_cpu_ack = g_valid && !g_owner && (cyc == g_cyc + MEM_LAT + 1);
    e_dma_ack = g_valid &&  g_owner && (cyc == g_cyc + MEM_LAT + 1);
    if (check_en) begin
      chk("mem_we", 32'(mem_we), 32'(e_mem_we));
      chk("cpu_ack", 32'(cpu_ack), 32'(e_cpu_ack));
      chk("dma_ack", 32'(dma_ack), 32'(e_dma_ack));
      chk("mem_owner", 32'(mem_owner), 32'(g_owner));
      chk("mem_adr", mem_adr, g_adr);
      chk("mem_wd", mem_wd, g_wd);
      chk("cpu_rd", cpu_rd, e_cpu_rd);
      chk("dma_rd", dma_rd, e_dma_rd);
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e_cpu_ack));
    end
    if (reset) begin
      g_valid = 0; g_owner = 0; g_we = 0; g_adr = 0; g_wd = 0;
      e_cpu_rd = 0; e_dma_rd = 0; streak = 0;
      next_free = cyc + 1;
    end else if (cyc >= next_free && (cpu_req || dma_req)) begin
`ifdef MEMARB_FAIRNESS_EN
      pick_dma = dma_req && (!cpu_req || streak == MAX_BURST);
      streak = (!pick_dma && dma_req) ? streak + 1 : 0;
`else
      pick_dma = dma_req && !cpu_req;
`endif
      g_valid = 1; g_cyc = cyc; g_owner = pick_dma;
      g_we  = pick_dma ? dma_we  : cpu_we;
      g_adr = pick_dma ? dma_adr : cpu_adr;
      g_wd  = pick_dma ? dma_wd  : cpu_wd;
      idx = int'(g_adr[7:2]);
      g_rdata = ref_wr[idx] ? ref_mem[idx] : init_val(idx);
      if (g_we) begin
        ref_mem[idx] = g_wd;
        ref_wr[idx]  = 1'b1;
      end
      next_free = cyc + MEM_LAT + 2;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    bit ca, da;
    int k;
    k = 0;
    while ((cpu_req || dma_req) && k < 60) begin
      @(negedge clk); ca = cpu_ack; da = dma_ack;
      step();
      if (ca) cpu_req = 0;
      if (da) dma_req = 0;
      k++;
    end
    if (cpu_req || dma_req) begin
      n_chk++; n_fail++;
      $display("FAIL %s: requests still pending after %0d cycles, got no ack expected ack", name, k);
      cpu_req = 0; dma_req = 0;
    end
  endtask

  initial begin
    int n_cpu;
    bit got_dma, ca, da;

    repeat (3) step();
    reset = 0;
    check_en = 1;
    @(negedge clk);
    chk("rst_owner", 32'(mem_owner), 32'd0);
    chk("rst_acks", 32'({cpu_ack, dma_ack, mem_we}), 32'd0);
    chk("rst_rd", cpu_rd | dma_rd | mem_adr | mem_wd, 32'd0);
    step();

    // CPU read of address 80
    cpu_req = 1; cpu_we = 0; cpu_adr = 32'd80;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rd80_ack", 32'(cpu_ack), 32'(k == 3));
      chk("rd80_dma_ack", 32'(dma_ack), 32'd0);
      if (k == 3) chk("rd80_data", cpu_rd, 32'hFFFF_FFC0);
      step();
      if (k == 3) cpu_req = 0;
    end

    // CPU write of -64 to address 84
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'd84; cpu_wd = -32'sd64;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("wr84_we", 32'(mem_we), 32'(k == 1));
      chk("wr84_ack", 32'(cpu_ack), 32'(k == 3));
      if (k == 1) begin
        chk("wr84_adr", mem_adr, 32'd84);
        chk("wr84_wd", mem_wd, 32'hFFFF_FFC0);
      end
      step();
      if (k == 3) cpu_req = 0;
    end

    // simultaneous requests: CPU first, then DMA
    cpu_req = 1; cpu_we = 0; cpu_adr = 32'd8;
    dma_req = 1; dma_we = 0; dma_adr = 32'd12;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("both_cpu_ack", 32'(cpu_ack), 32'(k == 3));
      chk("both_dma_ack", 32'(dma_ack), 32'(k == 7));
      chk("both_owner", 32'(mem_owner), 32'(k >= 5));
      step();
      if (k == 3) cpu_req = 0;
      if (k == 7) dma_req = 0;
    end

    // lone DMA read of 0x10
    dma_req = 1; dma_we = 0; dma_adr = 32'h10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("dma10_ack", 32'(dma_ack), 32'(k == 3));
      chk("dma10_stall", 32'(cpu_stall), 32'd0);
      if (k >= 1) chk("dma10_owner", 32'(mem_owner), 32'd1);
      if (k == 3) chk("dma10_data", dma_rd, 32'h1234_5678);
      step();
      if (k == 3) dma_req = 0;
    end

    // reset during BUSY of a DMA write
    dma_req = 1; dma_we = 1; dma_adr = 32'h20; dma_wd = 32'h0000_00AA;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("rstbusy_dma_ack", 32'(dma_ack), 32'd0);
      chk("rstbusy_we", 32'(mem_we), 32'(k == 1));
      if (k == 3) begin
        chk("rstbusy_outs", 32'({cpu_ack, mem_owner, mem_we}), 32'd0);
        chk("rstbusy_regs", cpu_rd | dma_rd | mem_adr | mem_wd, 32'd0);
        chk("rstbusy_committed", env_mem[8], 32'h0000_00AA);
      end
      step();
      if (k == 1) begin reset = 1; dma_req = 0; end
      if (k == 2) reset = 0;
    end

    // continuous CPU traffic with DMA waiting
    cpu_req = 1; cpu_we = 0; cpu_adr = $urandom;
    dma_req = 1; dma_we = 0; dma_adr = 32'h40;
    n_cpu = 0; got_dma = 0;
    for (int k = 0; k < 120 && !got_dma && n_cpu < 20; k++) begin
      @(negedge clk); ca = cpu_ack; da = dma_ack;
      if (da) got_dma = 1;
      if (ca) n_cpu++;
      step();
      if (ca) cpu_adr = $urandom;
      if (da) dma_req = 0;
    end
`ifdef MEMARB_FAIRNESS_EN
    chk("fair_dma_granted", 32'(got_dma), 32'd1);
    chk("fair_cpu_before_dma", 32'(n_cpu), 32'd4);
`else
    chk("starve_no_dma_ack", 32'(got_dma), 32'd0);
    chk("starve_cpu_count", 32'(n_cpu), 32'd20);
`endif
    drain("fair_drain");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); ca = cpu_ack; da = dma_ack;
      step();
      reset = ($urandom_range(0, 499) == 0);
      if (cpu_req) begin
        if (ca) begin
          if ($urandom_range(0, 3) != 0) begin
            cpu_we = $urandom_range(0, 1); cpu_adr = $urandom; cpu_wd = $urandom;
          end else cpu_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_req = 1; cpu_we = $urandom_range(0, 1); cpu_adr = $urandom; cpu_wd = $urandom;
      end
      if (dma_req) begin
        if (da) begin
          if ($urandom_range(0, 3) != 0) begin
            dma_we = $urandom_range(0, 1); dma_adr = $urandom; dma_wd = $urandom;
          end else dma_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        dma_req = 1; dma_we = $urandom_range(0, 1); dma_adr = $urandom; dma_wd = $urandom;
      end
    end
    reset = 0;
    drain("random_drain");
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
